branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Parametrised successor to the combinational branch-resolution logic: resolves B-type, JAL and JALR in Execute from ALU flags.
- Also owns a direct-mapped branch target buffer. Each entry holds a 2-bit saturating counter, used as a branch history table (BHT).
- The Fetch stage queries the table; Execute compares the actual outcome against the prediction, raises a mispredict/redirect and trains the table.
- Saturating performance counters track resolved control-flow instructions and mispredicts.

Parameters:
- ADDR_WIDTH, 32, PC width
- BTB_DEPTH, 64, table entries; power of two and at least 2
- CNT_WIDTH, 2, saturating counter width
- PERF_WIDTH, 32, performance counter width
- OP_WIDTH, 7, opcode width
- FUNCT3_WIDTH, 3, funct3 width

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- PCF  in  ADDR_WIDTH  Fetch PC
- PredTakenF  out  1  Fetch prediction
- PredTargetF  out  ADDR_WIDTH  predicted target
- ValidE  in  1  Execute holds a real instruction, not a bubble
- StallE  in  1  Execute held
- op  in  OP_WIDTH  Execute opcode
- funct3  in  FUNCT3_WIDTH  Execute funct3
- Zero, N, C, V  in  1 each  ALU flags of rs1-rs2; C=1 means rs1<rs2 unsigned (borrow)
- PCE  in  ADDR_WIDTH  Execute PC
- PCPlus4E  in  ADDR_WIDTH  PCE+4
- PCTargetE  in  ADDR_WIDTH  PC-relative target (B, JAL)
- JalrTargetE  in  ADDR_WIDTH  rs1+imm (JALR)
- PredTakenE, PredTargetE  in  1, ADDR_WIDTH  prediction piped from Fetch
- MispredictE  out  1  flush and redirect
- RedirectPCE  out  ADDR_WIDTH  correct next PC
- BranchCount  out  PERF_WIDTH  resolved control-flow count
- MispredCount  out  PERF_WIDTH  mispredict count

Behaviour:
- Index = PC[IDX+1:2], where IDX = log2(BTB_DEPTH). Tag = PC[ADDR_WIDTH-1:IDX+2].
- Entry contents: valid, tag, target, counter.
- Fetch lookup is combinational from registered state. PredTakenF = valid & tag match & counter MSB. PredTargetF = entry target on hit, else PCF+4.
- Decode: JAL op=1101111, JALR op=1100111, B-type op=1100011.
- Taken rules:
  - beq: Zero
  - bne: ~Zero
  - blt: N^V
  - bge: ~(N^V)
  - bltu: C
  - bgeu: ~C
  - funct3 010/011: not taken
  - JAL/JALR: always taken
  - any other op: not control flow
- ActualTarget:
  - JAL, B-type: PCTargetE
  - JALR: JalrTargetE with bit0 cleared
- Resolve condition: ValidE & ~StallE & control-flow op.
- MispredictE (combinational, only under the resolve condition):
  - asserted when taken != PredTakenE, or when taken & PredTargetE != ActualTarget
  - 0 otherwise, including on bubbles and stalls
- RedirectPCE = taken ? ActualTarget : PCPlus4E. Valid only while MispredictE=1.
- Training happens on the rising edge under the resolve condition:
  - B-type hit: counter +1 if taken, else -1, saturating at 0 and 2^CNT_WIDTH-1. If taken, target is rewritten.
  - B-type miss and taken: allocate the entry (valid, tag, target) with counter = weakly taken (10).
  - B-type miss and not taken: no write.
  - JAL/JALR: allocate or overwrite the entry with counter saturated to max.
- Same-cycle lookup and update of the same index: Fetch sees the pre-update contents; the new value is visible the next cycle.
- Perf counters, under the resolve condition:
  - BranchCount +1
  - MispredCount +1 when MispredictE=1
  - both saturate at all-ones and never wrap
- Reset (async assert; deassertion synchronised upstream):
  - all valid=0, counters=01 (weakly not taken), targets=0, perf counters=0
  - outputs then PredTakenF=0, PredTargetF=PCF+4, MispredictE=0
- Reset asserted mid-operation discards any pending update.
- StallE=1 freezes training and counting, and forces MispredictE=0.

Decomposition:
- Package branch_pkg holds:
  - opcode constants OP_JAL, OP_JALR, OP_BRANCH
  - funct3 enum (BEQ, BNE, BLT, BGE, BLTU, BGEU)
  - counter constants CNT_WNT, CNT_WT
- Sub-module btb_table: register-array storage with one combinational read port and one write port, parametrised on depth and widths.
- Resolve and training logic stay in branch_predict_unit.

Test Plan:
- Reset, then PCF=0x100 -> PredTakenF=0, PredTargetF=0x104, both perf counters 0.
- beq at PCE=0x100 with Zero=1, PredTakenE=0, PCTargetE=0x80 -> MispredictE=1, RedirectPCE=0x80. Next cycle PCF=0x100 -> PredTakenF=1, PredTargetF=0x80.
- Same branch resolved taken 3 more times, then not taken once -> counter is 11 then 10, and PredTakenF stays 1. Two further not-taken resolutions -> counter 00, PredTakenF=0.
- blt with N=1, V=1 -> not taken; with N=1, V=0 -> taken. bltu with C=1 -> taken; bgeu with C=1 -> not taken.
- JALR predicted taken to 0x200 with JalrTargetE=0x301 -> MispredictE=1, RedirectPCE=0x300, entry target becomes 0x300.
- StallE=1 during a mispredicting branch -> MispredictE=0, counts and table unchanged. Force MispredCount to all-ones and mispredict once -> count stays all-ones. rst_n low mid-run -> all entries invalid immediately.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared decode constants and encodings for the branch predict unit.
package branch_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_f3_e;

    // 2-bit reference encodings; wider counters scale these up in the top.
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: one combinational Fetch read port and one
// write port whose addressed entry is also read back for read-modify-write.
module btb_table
    import branch_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6,
    parameter int TAG_W = 24,
    parameter int TGT_W = 32,
    parameter int CNT_W = 2,
    parameter logic [CNT_W-1:0] CNT_RST = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [TGT_W-1:0] rd_target,
    output logic [CNT_W-1:0] rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [TGT_W-1:0] wr_target,
    input  logic [CNT_W-1:0] wr_cnt,
    output logic             wr_old_valid,
    output logic [TAG_W-1:0] wr_old_tag,
    output logic [TGT_W-1:0] wr_old_target,
    output logic [CNT_W-1:0] wr_old_cnt
);

    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0][TAG_W-1:0] tag_q;
    logic [DEPTH-1:0][TGT_W-1:0] tgt_q;
    logic [DEPTH-1:0][CNT_W-1:0] cnt_q;

    assign rd_valid      = valid_q[rd_idx];
    assign rd_tag        = tag_q[rd_idx];
    assign rd_target     = tgt_q[rd_idx];
    assign rd_cnt        = cnt_q[rd_idx];

    assign wr_old_valid  = valid_q[wr_idx];
    assign wr_old_tag    = tag_q[wr_idx];
    assign wr_old_target = tgt_q[wr_idx];
    assign wr_old_cnt    = cnt_q[wr_idx];

    // Entry storage; a write always leaves the entry valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            tag_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= {DEPTH{CNT_RST}};
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            tag_q[wr_idx]   <= wr_tag;
            tgt_q[wr_idx]   <= wr_target;
            cnt_q[wr_idx]   <= wr_cnt;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Execute-stage branch resolution with a BTB/BHT predictor for Fetch and
// saturating performance counters.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int BTB_DEPTH    = 64,
    parameter int CNT_WIDTH    = 2,
    parameter int PERF_WIDTH   = 32,
    parameter int OP_WIDTH     = 7,
    parameter int FUNCT3_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   PCF,
    output logic                    PredTakenF,
    output logic [ADDR_WIDTH-1:0]   PredTargetF,
    input  logic                    ValidE,
    input  logic                    StallE,
    input  logic [OP_WIDTH-1:0]     op,
    input  logic [FUNCT3_WIDTH-1:0] funct3,
    input  logic                    Zero,
    input  logic                    N,
    input  logic                    C,
    input  logic                    V,
    input  logic [ADDR_WIDTH-1:0]   PCE,
    input  logic [ADDR_WIDTH-1:0]   PCPlus4E,
    input  logic [ADDR_WIDTH-1:0]   PCTargetE,
    input  logic [ADDR_WIDTH-1:0]   JalrTargetE,
    input  logic                    PredTakenE,
    input  logic [ADDR_WIDTH-1:0]   PredTargetE,
    output logic                    MispredictE,
    output logic [ADDR_WIDTH-1:0]   RedirectPCE,
    output logic [PERF_WIDTH-1:0]   BranchCount,
    output logic [PERF_WIDTH-1:0]   MispredCount
);

    localparam int IDX   = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_WIDTH - IDX - 2;
    localparam logic [CNT_WIDTH-1:0] CNT_WT_P  = CNT_WIDTH'(CNT_WT) << (CNT_WIDTH - 2);
    localparam logic [CNT_WIDTH-1:0] CNT_WNT_P = CNT_WT_P - CNT_WIDTH'(1);

    // Word-aligned PCs: the byte offset never selects an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

    logic                  f_valid, e_valid;
    logic [TAG_W-1:0]      f_tag, e_tag;
    logic [ADDR_WIDTH-1:0] f_target, e_target;
    logic [CNT_WIDTH-1:0]  f_cnt, e_cnt;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_target;
    logic [CNT_WIDTH-1:0]  wr_cnt, cnt_trained;
    logic                  f_hit, e_hit;

    btb_table #(
        .DEPTH  (BTB_DEPTH),
        .IDX_W  (IDX),
        .TAG_W  (TAG_W),
        .TGT_W  (ADDR_WIDTH),
        .CNT_W  (CNT_WIDTH),
        .CNT_RST(CNT_WNT_P)
    ) u_btb (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_idx       (PCF[IDX+1:2]),
        .rd_valid     (f_valid),
        .rd_tag       (f_tag),
        .rd_target    (f_target),
        .rd_cnt       (f_cnt),
        .wr_en        (wr_en),
        .wr_idx       (PCE[IDX+1:2]),
        .wr_tag       (PCE[ADDR_WIDTH-1:IDX+2]),
        .wr_target    (wr_target),
        .wr_cnt       (wr_cnt),
        .wr_old_valid (e_valid),
        .wr_old_tag   (e_tag),
        .wr_old_target(e_target),
        .wr_old_cnt   (e_cnt)
    );

    // Fetch prediction straight from registered table state.
    assign f_hit       = f_valid && (f_tag == PCF[ADDR_WIDTH-1:IDX+2]);
    assign PredTakenF  = f_hit && f_cnt[CNT_WIDTH-1];
    assign PredTargetF = f_hit ? f_target : PCF + ADDR_WIDTH'(4);

    logic is_jal, is_jalr, is_br, resolve, taken;
    logic [ADDR_WIDTH-1:0] actual_tgt;

    assign is_jal  = (op == OP_WIDTH'(OP_JAL));
    assign is_jalr = (op == OP_WIDTH'(OP_JALR));
    assign is_br   = (op == OP_WIDTH'(OP_BRANCH));
    assign resolve = ValidE && !StallE && (is_jal || is_jalr || is_br);

    // Branch condition from the ALU flags of rs1-rs2.
    always_comb begin
        taken = 1'b0;
        if (is_jal || is_jalr) begin
            taken = 1'b1;
        end else if (is_br) begin
            case (funct3[2:0])
                F3_BEQ:  taken = Zero;
                F3_BNE:  taken = !Zero;
                F3_BLT:  taken = N ^ V;
                F3_BGE:  taken = !(N ^ V);
                F3_BLTU: taken = C;
                F3_BGEU: taken = !C;
                default: taken = 1'b0;
            endcase
        end
    end

    assign actual_tgt  = is_jalr ? (JalrTargetE & ~ADDR_WIDTH'(1)) : PCTargetE;
    assign MispredictE = resolve && ((taken != PredTakenE) ||
                                     (taken && (PredTargetE != actual_tgt)));
    assign RedirectPCE = taken ? actual_tgt : PCPlus4E;

    // Saturating step of the hit entry's history counter.
    always_comb begin
        cnt_trained = e_cnt;
        if (taken && !(&e_cnt))
            cnt_trained = e_cnt + CNT_WIDTH'(1);
        else if (!taken && (e_cnt != '0))
            cnt_trained = e_cnt - CNT_WIDTH'(1);
    end

    // Training write: branches train on hit or allocate when taken; jumps always allocate strong.
    always_comb begin
        e_hit     = e_valid && (e_tag == PCE[ADDR_WIDTH-1:IDX+2]);
        wr_en     = 1'b0;
        wr_target = actual_tgt;
        wr_cnt    = '1;
        if (resolve) begin
            if (is_br) begin
                if (e_hit) begin
                    wr_en     = 1'b1;
                    wr_cnt    = cnt_trained;
                    wr_target = taken ? actual_tgt : e_target;
                end else if (taken) begin
                    wr_en  = 1'b1;
                    wr_cnt = CNT_WT_P;
                end
            end else begin
                wr_en = 1'b1;
            end
        end
    end

    // Performance counters, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BranchCount  <= '0;
            MispredCount <= '0;
        end else if (resolve) begin
            if (!(&BranchCount))
                BranchCount <= BranchCount + PERF_WIDTH'(1);
            if (MispredictE && !(&MispredCount))
                MispredCount <= MispredCount + PERF_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with a per-cycle reference model.
module tb_branch_predict_unit;

    localparam int AW = 32;
    localparam int DEPTH = 16;
    localparam int PW = 4;
    localparam int PMAX = (1 << PW) - 1;
    localparam logic [6:0] B = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;

    logic clk = 1'b0;
    logic rst_n;
    logic [AW-1:0] PCF, PredTargetF, PCE, PCPlus4E, PCTargetE, JalrTargetE, PredTargetE, RedirectPCE;
    logic PredTakenF, ValidE, StallE, Zero, N, C, V, PredTakenE, MispredictE;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [PW-1:0] BranchCount, MispredCount;
    logic [31:0] ra, rb;

    int ncmp = 0;
    int nerr = 0;

    branch_predict_unit #(
        .ADDR_WIDTH(AW), .BTB_DEPTH(DEPTH), .CNT_WIDTH(2),
        .PERF_WIDTH(PW), .OP_WIDTH(7), .FUNCT3_WIDTH(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .PCF(PCF), .PredTakenF(PredTakenF),
        .PredTargetF(PredTargetF), .ValidE(ValidE), .StallE(StallE), .op(op),
        .funct3(funct3), .Zero(Zero), .N(N), .C(C), .V(V), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .PCTargetE(PCTargetE), .JalrTargetE(JalrTargetE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .MispredictE(MispredictE),
        .RedirectPCE(RedirectPCE), .BranchCount(BranchCount), .MispredCount(MispredCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: table as plain arrays, counters as integers 0..3.
    bit          mv[DEPTH];
    logic [31:0] mt[DEPTH];
    logic [31:0] mtg[DEPTH];
    int          mc[DEPTH];
    int          mbc, mmc;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    // Outcome of the Execute instruction judged from the operand values themselves.
    function automatic void eval(output bit res, output bit tk, output logic [31:0] act, output bit mis);
        bit isb, isj, isjr;
        isb  = (op == B);
        isj  = (op == JAL);
        isjr = (op == JALR);
        tk = 1'b0;
        if (isj || isjr) tk = 1'b1;
        else if (isb) begin
            case (funct3)
                3'd0: tk = (ra == rb);
                3'd1: tk = (ra != rb);
                3'd4: tk = ($signed(ra) <  $signed(rb));
                3'd5: tk = ($signed(ra) >= $signed(rb));
                3'd6: tk = (ra <  rb);
                3'd7: tk = (ra >= rb);
                default: tk = 1'b0;
            endcase
        end
        act = isjr ? {JalrTargetE[31:1], 1'b0} : PCTargetE;
        res = ValidE && !StallE && (isb || isj || isjr);
        mis = res && ((tk != PredTakenE) || (tk && PredTargetE != act));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit res, tk, mis, hit;
        logic [31:0] act;
        int i;
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mv[k] = 1'b0; mt[k] = '0; mtg[k] = '0; mc[k] = 1;
            end
            mbc = 0; mmc = 0;
        end else begin
            eval(res, tk, act, mis);
            if (res) begin
                if (mbc < PMAX) mbc++;
                if (mis && mmc < PMAX) mmc++;
                i = idx_of(PCE);
                hit = mv[i] && (mt[i] == (PCE >> 6));
                if (op == B) begin
                    if (hit) begin
                        mc[i] = tk ? ((mc[i] < 3) ? mc[i] + 1 : 3) : ((mc[i] > 0) ? mc[i] - 1 : 0);
                        if (tk) mtg[i] = act;
                    end else if (tk) begin
                        mv[i] = 1'b1; mt[i] = PCE >> 6; mtg[i] = act; mc[i] = 2;
                    end
                end else begin
                    mv[i] = 1'b1; mt[i] = PCE >> 6; mtg[i] = act; mc[i] = 3;
                end
            end
        end
    end

    // Compare every output against the model each cycle out of reset.
    always @(negedge clk) begin
        bit res, tk, mis, hit;
        logic [31:0] act;
        int fi;
        if (rst_n) begin
            fi = idx_of(PCF);
            hit = mv[fi] && (mt[fi] == (PCF >> 6));
            chk("PredTakenF", {31'd0, PredTakenF}, {31'd0, hit && mc[fi] >= 2});
            chk("PredTargetF", PredTargetF, hit ? mtg[fi] : PCF + 32'd4);
            eval(res, tk, act, mis);
            chk("MispredictE", {31'd0, MispredictE}, {31'd0, mis});
            if (mis) chk("RedirectPCE", RedirectPCE, tk ? act : PCPlus4E);
            chk("BranchCount", {28'd0, BranchCount}, mbc);
            chk("MispredCount", {28'd0, MispredCount}, mmc);
        end
    end

    task automatic ex(input logic [6:0] o, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pce, input logic [31:0] tgt, input logic [31:0] jt,
                      input bit pt, input logic [31:0] ptg, input bit stall = 1'b0);
        logic [32:0] d;
        @(posedge clk); #1;
        ra = a; rb = b;
        d = {1'b0, a} - {1'b0, b};
        Zero = (a == b); N = d[31]; C = d[32];
        V = (a[31] != b[31]) && (d[31] != a[31]);
        op = o; funct3 = f3; PCE = pce; PCF = pce; PCPlus4E = pce + 32'd4;
        PCTargetE = tgt; JalrTargetE = jt; PredTakenE = pt; PredTargetE = ptg;
        ValidE = 1'b1; StallE = stall;
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] pcf);
        @(posedge clk); #1;
        ValidE = 1'b0; StallE = 1'b0; PCF = pcf;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ValidE = 1'b0; StallE = 1'b0; op = '0; funct3 = '0;
        ra = '0; rb = '0; Zero = 0; N = 0; C = 0; V = 0;
        PCF = 32'h100; PCE = '0; PCPlus4E = '0; PCTargetE = '0; JalrTargetE = '0;
        PredTakenE = 1'b0; PredTargetE = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_PredTakenF", {31'd0, PredTakenF}, 32'd0);
        chk("rst_PredTargetF", PredTargetF, 32'h104);
        chk("rst_BranchCount", {28'd0, BranchCount}, 32'd0);
        chk("rst_MispredCount", {28'd0, MispredCount}, 32'd0);

        // beq taken, predicted not taken: allocate weakly taken
        ex(B, 3'd0, 5, 5, 32'h100, 32'h80, 0, 1'b0, 0);
        chk("beq_mis", {31'd0, MispredictE}, 32'd1);
        chk("beq_redir", RedirectPCE, 32'h80);
        chk("beq_same_cycle_pred", {31'd0, PredTakenF}, 32'd0);
        idle(32'h100);
        chk("beq_alloc_pt", {31'd0, PredTakenF}, 32'd1);
        chk("beq_alloc_tgt", PredTargetF, 32'h80);
        repeat (3) ex(B, 3'd0, 5, 5, 32'h100, 32'h80, 0, 1'b1, 32'h80);
        ex(B, 3'd0, 1, 2, 32'h100, 32'h80, 0, 1'b1, 32'h80);
        chk("beq_nt_mis", {31'd0, MispredictE}, 32'd1);
        chk("beq_nt_redir", RedirectPCE, 32'h104);
        idle(32'h100);
        chk("cnt10_pt", {31'd0, PredTakenF}, 32'd1);
        ex(B, 3'd0, 1, 2, 32'h100, 32'h80, 0, 1'b1, 32'h80);
        ex(B, 3'd0, 1, 2, 32'h100, 32'h80, 0, 1'b0, 32'h80);
        idle(32'h100);
        chk("cnt00_pt", {31'd0, PredTakenF}, 32'd0);
        chk("cnt00_tgt", PredTargetF, 32'h80);
        idle(32'h140);
        chk("tag_miss_tgt", PredTargetF, 32'h144);

        // signed/unsigned compares and reserved funct3
        ex(B, 3'd4, 32'h7fffffff, 32'hffffffff, 32'h108, 32'h40, 0, 1'b0, 0);
        chk("blt_nv_mis", {31'd0, MispredictE}, 32'd0);
        ex(B, 3'd4, 1, 2, 32'h108, 32'h40, 0, 1'b0, 0);
        chk("blt_n_redir", RedirectPCE, 32'h40);
        ex(B, 3'd6, 1, 2, 32'h10c, 32'h50, 0, 1'b0, 0);
        chk("bltu_mis", {31'd0, MispredictE}, 32'd1);
        ex(B, 3'd7, 1, 2, 32'h110, 32'h60, 0, 1'b1, 32'h60);
        chk("bgeu_redir", RedirectPCE, 32'h114);
        ex(B, 3'd2, 5, 5, 32'h114, 32'h70, 0, 1'b1, 32'h70);
        chk("f3_010_redir", RedirectPCE, 32'h118);

        // JALR target with bit0 cleared, then JAL
        ex(JALR, 3'd0, 0, 0, 32'h184, 0, 32'h301, 1'b1, 32'h200);
        chk("jalr_mis", {31'd0, MispredictE}, 32'd1);
        chk("jalr_redir", RedirectPCE, 32'h300);
        idle(32'h184);
        chk("jalr_pt", {31'd0, PredTakenF}, 32'd1);
        chk("jalr_tgt", PredTargetF, 32'h300);
        ex(JAL, 3'd0, 0, 0, 32'h118, 32'h400, 0, 1'b0, 0);
        chk("jal_redir", RedirectPCE, 32'h400);
        ex(7'b0110011, 3'd0, 0, 0, 32'h11c, 32'h44, 0, 1'b1, 32'h44);

        // stalled mispredicting branch has no effect
        ex(B, 3'd0, 5, 5, 32'h1000, 32'h90, 0, 1'b0, 0, 1'b1);
        chk("stall_mis", {31'd0, MispredictE}, 32'd0);
        idle(32'h1000);
        chk("stall_no_alloc", {31'd0, PredTakenF}, 32'd0);
        chk("stall_tgt", PredTargetF, 32'h1004);

        // drive both perf counters into saturation
        repeat (20) ex(JAL, 3'd0, 0, 0, 32'h120, 32'h500, 0, 1'b0, 0);
        idle(32'h120);
        chk("sat_branch", {28'd0, BranchCount}, 32'hf);
        chk("sat_mispred", {28'd0, MispredCount}, 32'hf);

        // reset in the middle of a resolving cycle drops the pending write
        ex(JAL, 3'd0, 0, 0, 32'h124, 32'h600, 0, 1'b0, 0);
        PCF = 32'h184;
        #1 chk("pre_rst_pt", {31'd0, PredTakenF}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_pt", {31'd0, PredTakenF}, 32'd0);
        chk("rst_mid_tgt", PredTargetF, 32'h188);
        chk("rst_mid_bc", {28'd0, BranchCount}, 32'd0);
        chk("rst_mid_mc", {28'd0, MispredCount}, 32'd0);
        ValidE = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        idle(32'h124);
        chk("rst_discard_pt", {31'd0, PredTakenF}, 32'd0);
        chk("rst_discard_tgt", PredTargetF, 32'h128);
        idle(32'h184);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
